scroll_tile_gen: RTL and testbench
==================================

Name: scroll_tile_gen

Overview:
- Parametrised successor of the single-direction checkerboard generator in the VGA pattern set.
- Produces a two-colour tiled pattern with configurable tile size and colours, scrolled by a fixed-point per-frame step.
- Supports four scroll directions and a pause control, with a registered RGB output.
- Sits between the sync/coordinate generator and the pattern mux; step_size comes from speed_controller.

Parameters:
- X_W, 10: width of x coordinate.
- Y_W, 10: width of y coordinate.
- TILE_LOG2, 5: tile edge = 2^TILE_LOG2 pixels; legal range 1..(min(X_W,Y_W)-1).
- OFF_W, 8: integer offset width; must be >= TILE_LOG2+1.
- FRAC_W, 2: fractional bits of step and accumulator.
- STEP_W, 3: step_size width, unsigned fixed point with FRAC_W fractional bits.
- FG_COLOR, 6'b100100: foreground RGB222.
- BG_COLOR, 6'b000000: background RGB222.
- CYCLE_FRAMES, 16: frames per palette step; used only with COLOR_CYCLE_EN.

Ports:
- clk  in  1  pixel clock (one clock domain).
- rst_n  in  1  asynchronous active-low reset.
- x  in  X_W  current pixel column.
- y  in  Y_W  current pixel row.
- next_frame  in  1  one-cycle pulse at frame boundary.
- step_size  in  STEP_W  per-frame scroll step (int.frac).
- mode_req  in  2  requested direction: 0=left, 1=right, 2=down, 3=diagonal.
- pause  in  1  freeze scroll when high.
- rgb  out  6  registered pixel colour.

Behaviour:
- Reset: asynchronous on rst_n low. Reset values: accumulator {off,frac}=0, mode_act=0 (left), rgb=BG_COLOR; phase=0 and frame counter=0 when COLOR_CYCLE_EN is compiled in.
- Accumulator: on next_frame && !pause, {off,frac} <= {off,frac} + step_size (zero-extended).
  - Wraps modulo 2^(OFF_W+FRAC_W); carry out of frac propagates into off.
  - With pause high, {off,frac} holds.
- Mode: mode_act <= mode_req on every next_frame, regardless of pause.
  - Changing mode_req mid-frame has no effect until the next next_frame.
  - Offset is never cleared on a mode change.
- Shifted coordinates (off zero-extended or truncated to the coordinate width; sums truncated):
  - left: sx = x + off, sy = y.
  - right: sx = x - off, sy = y.
  - down: sx = x, sy = y - off.
  - diagonal: sx = x + off, sy = y + off.
- Tile select: t = sx[TILE_LOG2] ^ sy[TILE_LOG2].
- Output: rgb <= t ? fg : bg every clock, giving 1-cycle latency from x/y to rgb.
- next_frame cycle: the accumulator and mode update take effect on the following clock's pixel. The pixel computed in the next_frame cycle itself uses the old values.
- Simultaneous events: rst_n low overrides next_frame. pause and a mode change together update the mode only.
- step_size=0 yields a static pattern. The maximum step (2^STEP_W-1)/2^FRAC_W per frame is legal with no saturation.
- Assertion-time check: OFF_W >= TILE_LOG2+1 (elaboration error otherwise).

Optional Feature:
- Macro: SCROLL_TILE_COLOR_CYCLE_EN.
- Defined:
  - A frame counter counts next_frame pulses, including paused frames.
  - Every CYCLE_FRAMES pulses, the counter returns to 0 and a 2-bit phase increments, wrapping 3->0.
  - fg = PALETTE[phase], with PALETTE from the package and PALETTE[0]=FG_COLOR; bg remains BG_COLOR.
- Undefined: fg = FG_COLOR constant; no counter or phase registers are synthesised.

Decomposition:
- Shared package pattern_pkg:
  - mode encodings MODE_LEFT/RIGHT/DOWN/DIAG;
  - RGB222 colour constants;
  - 4-entry PALETTE array;
  - rgb222 typedef.
- One sub-module: frac_step_accum (parametrised OFF_W/FRAC_W/STEP_W fixed-point accumulator with enable). It is reusable by other scrolling patterns.

Test Plan:
- Reset: rst_n=0 mid-frame with off=5 -> off=0, rgb=BG immediately; after release, x=0,y=0 -> rgb=BG next clock.
- Fixed-point accumulate: step=3'b101 (1.25), 4 next_frame pulses, mode left -> off=5. Then x=27,y=0 -> sx=32, rgb=FG one cycle later; x=26 -> BG.
- Direction: off=5, mode right, x=5,y=0 -> sx=0, BG; x=4 -> sx wraps to 1023, bit5=1, FG. Diagonal with off=5, x=27,y=27 -> both bits 1, BG.
- Deferred mode: change mode_req 0->1 mid-frame -> output unchanged until the cycle after next_frame. With pause=1 over 3 pulses -> off held, mode still updates.
- Wrap: OFF_W=8, off=255.75 (frac=3), step=0.25 -> off=0, frac=0.
- COLOR_CYCLE_EN, CYCLE_FRAMES=16: after 16 pulses phase=1 and FG pixels show PALETTE[1]; after 64 pulses phase=0 again.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the VGA pattern generators: RGB222 type, scroll
// direction encodings, named colours and the colour-cycle palette.
package pattern_pkg;

  typedef logic [5:0] rgb222;

  localparam logic [1:0] MODE_LEFT  = 2'd0;
  localparam logic [1:0] MODE_RIGHT = 2'd1;
  localparam logic [1:0] MODE_DOWN  = 2'd2;
  localparam logic [1:0] MODE_DIAG  = 2'd3;

  // Bit layout is {R[1:0], G[1:0], B[1:0]}
  localparam rgb222 RGB_BLACK  = 6'b000000;
  localparam rgb222 RGB_AMBER  = 6'b100100;
  localparam rgb222 RGB_TEAL   = 6'b001001;
  localparam rgb222 RGB_VIOLET = 6'b010010;
  localparam rgb222 RGB_WHITE  = 6'b111111;

  localparam rgb222 PALETTE [0:3] = '{RGB_AMBER, RGB_TEAL, RGB_VIOLET, RGB_WHITE};

endpackage

// File: rtl/scroll_tile_gen_if.sv
// Pixel-stream bundle between the coordinate generator, scroll_tile_gen and the
// pattern mux. Widths must match the parameters of the attached generator.
interface scroll_tile_gen_if #(
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int STEP_W = 3
);
  import pattern_pkg::*;

  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic              next_frame;
  logic [STEP_W-1:0] step_size;
  logic [1:0]        mode_req;
  logic              pause;
  rgb222             rgb;

  modport master (
    output x, y, next_frame, step_size, mode_req, pause,
    input  rgb
  );

  modport slave (
    input  x, y, next_frame, step_size, mode_req, pause,
    output rgb
  );

endinterface

// File: rtl/frac_step_accum.sv
// Unsigned fixed-point {off,frac} accumulator: adds a zero-extended step when
// enabled and wraps modulo 2^(OFF_W+FRAC_W). Shared by scrolling patterns.
module frac_step_accum #(
  parameter int OFF_W  = 8,
  parameter int FRAC_W = 2,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  output logic [OFF_W-1:0]  off,
  output logic [FRAC_W-1:0] frac
);

  localparam int ACC_W = OFF_W + FRAC_W;

  logic [ACC_W-1:0] acc_p0;
  logic [ACC_W-1:0] acc_nxt;

  // Carry out of the fractional field falls straight into the integer field
  assign acc_nxt = acc_p0 + ACC_W'(step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0 <= '0;
    end else if (en) begin
      acc_p0 <= acc_nxt;
    end
  end

  assign {off, frac} = acc_p0;

endmodule

// File: rtl/scroll_tile_gen.sv
// Scrolling two-colour checkerboard with fixed-point per-frame step, four
// directions and pause. Optional palette cycling: SCROLL_TILE_COLOR_CYCLE_EN.
module scroll_tile_gen
  import pattern_pkg::*;
#(
  parameter int    X_W          = 10,
  parameter int    Y_W          = 10,
  parameter int    TILE_LOG2    = 5,
  parameter int    OFF_W        = 8,
  parameter int    FRAC_W       = 2,
  parameter int    STEP_W       = 3,
  parameter rgb222 FG_COLOR     = 6'b100100,
  parameter rgb222 BG_COLOR     = 6'b000000,
  parameter int    CYCLE_FRAMES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  scroll_tile_gen_if.slave pix
);

  localparam int MIN_XY = (X_W < Y_W) ? X_W : Y_W;

  generate
    if (OFF_W < TILE_LOG2 + 1) begin : g_bad_off_w
      $error("scroll_tile_gen: OFF_W (%0d) must be >= TILE_LOG2+1 (%0d)", OFF_W, TILE_LOG2 + 1);
    end
    if (TILE_LOG2 < 1 || TILE_LOG2 > MIN_XY - 1) begin : g_bad_tile
      $error("scroll_tile_gen: TILE_LOG2 (%0d) outside 1..%0d", TILE_LOG2, MIN_XY - 1);
    end
  endgenerate

  logic [OFF_W-1:0]  acc_off;
  logic [FRAC_W-1:0] acc_frac;
  logic              accum_en;
  logic [1:0]        mode_act;
  rgb222             fg;
  logic [X_W-1:0]    sx_p0;
  logic [Y_W-1:0]    sy_p0;
  logic [X_W-1:0]    off_x;
  logic [Y_W-1:0]    off_y;
  logic              tile_p0;
  rgb222             rgb_p1;

  assign accum_en = pix.next_frame && !pix.pause;

  frac_step_accum #(
    .OFF_W  (OFF_W),
    .FRAC_W (FRAC_W),
    .STEP_W (STEP_W)
  ) u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accum_en),
    .step  (pix.step_size),
    .off   (acc_off),
    .frac  (acc_frac)
  );

  // Direction is latched only at the frame boundary, independent of pause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_act <= MODE_LEFT;
    end else if (pix.next_frame) begin
      mode_act <= pix.mode_req;
    end
  end

`ifdef SCROLL_TILE_COLOR_CYCLE_EN
  localparam int CNT_W = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;
  logic [1:0]       phase;

  // Paused frames still count, so the palette keeps moving while the scroll is frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 2'd0;
    end else if (pix.next_frame) begin
      if (frame_cnt == CNT_W'(CYCLE_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= phase + 2'd1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign fg = (phase == 2'd0) ? FG_COLOR : PALETTE[phase];
`else
  assign fg = FG_COLOR;
`endif

  assign off_x = X_W'(acc_off);
  assign off_y = Y_W'(acc_off);

  // Stage p0: shifted coordinates and tile parity
  always_comb begin
    sx_p0 = pix.x;
    sy_p0 = pix.y;
    unique case (mode_act)
      MODE_LEFT:  sx_p0 = pix.x + off_x;
      MODE_RIGHT: sx_p0 = pix.x - off_x;
      MODE_DOWN:  sy_p0 = pix.y - off_y;
      MODE_DIAG: begin
        sx_p0 = pix.x + off_x;
        sy_p0 = pix.y + off_y;
      end
      default: begin
        sx_p0 = pix.x;
        sy_p0 = pix.y;
      end
    endcase
  end

  assign tile_p0 = sx_p0[TILE_LOG2] ^ sy_p0[TILE_LOG2];

  // Stage p1: registered colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p1 <= BG_COLOR;
    end else begin
      rgb_p1 <= tile_p0 ? fg : BG_COLOR;
    end
  end

  assign pix.rgb = rgb_p1;

endmodule

// File: tb/tb_scroll_tile_gen.sv
// Bench for scroll_tile_gen: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an arithmetic model.
module tb_scroll_tile_gen;
  import pattern_pkg::*;

  localparam int X_W = 10, Y_W = 10, TL = 5, OFF_W = 8, FRAC_W = 2, STEP_W = 3;
  localparam int CF = 16;
  localparam int FG = 6'b100100;
  localparam int BG = 6'b000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  scroll_tile_gen_if #(.X_W(X_W), .Y_W(Y_W), .STEP_W(STEP_W)) pix ();

  scroll_tile_gen #(
    .X_W(X_W), .Y_W(Y_W), .TILE_LOG2(TL), .OFF_W(OFF_W), .FRAC_W(FRAC_W),
    .STEP_W(STEP_W), .FG_COLOR(6'b100100), .BG_COLOR(6'b000000), .CYCLE_FRAMES(CF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pix   (pix)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: accumulator in units of 2^-FRAC_W, active direction, pulse count
  int acc_m    = 0;
  int mode_m   = 0;
  int pulses_m = 0;
  int exp_rgb  = 0;
  bit exp_vld  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pixel(input int xx, input int yy);
    int off, sx, sy, t, fgc, ph;
    off = acc_m >> FRAC_W;
    sx = xx;
    sy = yy;
    case (mode_m)
      0: sx = xx + off;
      1: sx = xx - off;
      2: sy = yy - off;
      default: begin sx = xx + off; sy = yy + off; end
    endcase
    sx = sx & ((1 << X_W) - 1);
    sy = sy & ((1 << Y_W) - 1);
    t = ((sx >> TL) ^ (sy >> TL)) & 1;
    fgc = FG;
`ifdef SCROLL_TILE_COLOR_CYCLE_EN
    ph = (pulses_m / CF) % 4;
    fgc = (ph == 0) ? FG : int'(PALETTE[ph]);
`else
    ph = 0;
`endif
    return (t != 0) ? (fgc + ph * 0) : BG;
  endfunction

  always @(negedge rst_n) begin
    acc_m    = 0;
    mode_m   = 0;
    pulses_m = 0;
    exp_vld  = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      exp_rgb = model_pixel(int'(pix.x), int'(pix.y));
      exp_vld = 1'b1;
      if (pix.next_frame) begin
        mode_m = int'(pix.mode_req);
        if (!pix.pause) acc_m = (acc_m + int'(pix.step_size)) % (1 << (OFF_W + FRAC_W));
        pulses_m++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && exp_vld) begin
      chk("rgb_vs_model", int'(pix.rgb), exp_rgb);
      chk("acc_vs_model", int'({dut.acc_off, dut.acc_frac}), acc_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      pix.next_frame = 1'b1;
      tick();
      pix.next_frame = 1'b0;
      tick();
    end
  endtask

  task automatic pixel_chk(input string name, input int xx, input int yy, input int exp);
    pix.x = X_W'(xx);
    pix.y = Y_W'(yy);
    tick();
    chk(name, int'(pix.rgb), exp);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_rgb_async", int'(pix.rgb), BG);
    chk("reset_off_async", int'(dut.acc_off), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pix.x = '0; pix.y = '0; pix.next_frame = 1'b0; pix.step_size = '0;
    pix.mode_req = 2'd0; pix.pause = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rgb_held", int'(pix.rgb), BG);
    rst_n = 1'b1;
    pixel_chk("post_reset_0_0", 0, 0, BG);

    // 4 x 1.25 = 5.0
    pix.step_size = 3'b101;
    pulse(4);
    chk("accum_off_5", int'(dut.acc_off), 5);
    chk("accum_frac_0", int'(dut.acc_frac), 0);
    chk("model_acc_5", acc_m, 20);
    pixel_chk("left_x27", 27, 0, FG);
    pixel_chk("left_x26", 26, 0, BG);

    // Reset mid-frame with off=5, then rebuild off=5
    pix.x = 10'd100;
    do_reset();
    pixel_chk("post_reset_again", 0, 0, BG);
    pulse(4);

    // Right: x=5 -> sx=0; x=4 -> sx=1023
    pix.step_size = '0;
    pix.mode_req = 2'd1;
    pulse(1);
    pixel_chk("right_x5", 5, 0, BG);
    pixel_chk("right_x4", 4, 0, FG);

    // Deferred direction change
    pix.mode_req = 2'd0;
    pixel_chk("defer_midframe", 4, 0, FG);
    pix.next_frame = 1'b1;
    pixel_chk("defer_nf_cycle", 4, 0, FG);
    pix.next_frame = 1'b0;
    pixel_chk("defer_after_nf", 4, 0, BG);

    // Diagonal
    pix.mode_req = 2'd3;
    pulse(1);
    pixel_chk("diag_27_27", 27, 27, BG);
    pixel_chk("diag_27_0", 27, 0, FG);

    // Down: y=4 -> sy=1023
    pix.mode_req = 2'd2;
    pulse(1);
    pixel_chk("down_y4", 0, 4, FG);
    pixel_chk("down_y5", 0, 5, BG);

    // Pause holds offset but still takes the mode
    pix.pause = 1'b1;
    pix.step_size = 3'b101;
    pix.mode_req = 2'd1;
    pulse(3);
    chk("pause_off_held", int'(dut.acc_off), 5);
    pixel_chk("pause_mode_right", 4, 0, FG);
    pix.pause = 1'b0;

    // Wrap: 255.75 + 0.25 -> 0.0
    do_reset();
    pix.mode_req = 2'd0;
    pix.step_size = 3'd7;
    pulse(146);
    pix.step_size = 3'd1;
    pulse(1);
    chk("wrap_pre_off", int'(dut.acc_off), 255);
    chk("wrap_pre_frac", int'(dut.acc_frac), 3);
    pulse(1);
    chk("wrap_off", int'(dut.acc_off), 0);
    chk("wrap_frac", int'(dut.acc_frac), 0);

`ifdef SCROLL_TILE_COLOR_CYCLE_EN
    do_reset();
    pix.step_size = '0;
    pix.mode_req = 2'd0;
    pulse(16);
    pixel_chk("cycle_phase1", 32, 0, int'(PALETTE[1]));
    pulse(48);
    pixel_chk("cycle_phase0", 32, 0, FG);
`endif

    // Randomized traffic, checked cycle by cycle by the model
    for (int i = 0; i < 3000; i++) begin
      pix.x = X_W'($urandom_range(0, (1 << X_W) - 1));
      pix.y = Y_W'($urandom_range(0, (1 << Y_W) - 1));
      pix.next_frame = ($urandom_range(0, 5) == 0);
      pix.pause = ($urandom_range(0, 3) == 0);
      pix.step_size = STEP_W'($urandom_range(0, (1 << STEP_W) - 1));
      pix.mode_req = 2'($urandom_range(0, 3));
      tick();
    end
    pix.next_frame = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
